uart_rx_fsm: RTL

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_fsm.sv | 119 +++++++++++
 2 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Holds the state encoding and the edge-index helper functions.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Last edge index of a bit for a given edge-counter width.
  function automatic int unsigned edge_max(input int unsigned edge_w);
    return (32'd1 << edge_w) - 32'd1;
  endfunction

  // Edge index at which the per-bit strobes fire.
  function automatic int unsigned check_point(input int unsigned edge_w);
    return edge_max(edge_w) - 32'd1;
  endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: sequences start/data/parity/stop bits and
// issues counter/sampler enables, one-cycle strobes and frame result pulses.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned BIT_COUNTER_WIDTH  = 4,
  parameter int unsigned EDGE_COUNTER_WIDTH = 3
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          RX_IN,
  input  logic                          PAR_EN,
  input  logic [BIT_COUNTER_WIDTH-1:0]  bit_cnt,
  input  logic [EDGE_COUNTER_WIDTH-1:0] edg_cnt,
  input  logic                          strt_glitch,
  input  logic                          par_err,
  input  logic                          stp_err,
  output logic                          cnt_en,
  output logic                          dat_samp_en,
  output logic                          deser_en,
  output logic                          strt_chk_en,
  output logic                          par_chk_en,
  output logic                          stp_chk_en,
  output logic                          data_valid,
  output logic                          frame_err
);

  localparam logic [EDGE_COUNTER_WIDTH-1:0] EDGE_MAX_C =
    EDGE_COUNTER_WIDTH'(edge_max(EDGE_COUNTER_WIDTH));
  localparam logic [EDGE_COUNTER_WIDTH-1:0] CHECK_PT_C =
    EDGE_COUNTER_WIDTH'(check_point(EDGE_COUNTER_WIDTH));
  localparam logic [BIT_COUNTER_WIDTH-1:0]  DATA_LAST_C =
    BIT_COUNTER_WIDTH'(DATA_WIDTH);

  state_e state_q, state_d;
  logic   par_en_q, par_en_d;
  logic   par_flag_q, par_flag_d;
  logic   data_valid_q, data_valid_d;
  logic   frame_err_q, frame_err_d;
  logic   bit_end, chk_pt;

  assign bit_end     = (edg_cnt == EDGE_MAX_C);
  assign chk_pt      = (edg_cnt == CHECK_PT_C);
  assign cnt_en      = (state_q != ST_IDLE);
  assign dat_samp_en = (state_q != ST_IDLE);
  assign data_valid  = data_valid_q;
  assign frame_err   = frame_err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      par_en_q     <= 1'b0;
      par_flag_q   <= 1'b0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      par_en_q     <= par_en_d;
      par_flag_q   <= par_flag_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    par_en_d     = par_en_q;
    par_flag_d   = par_flag_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    deser_en     = 1'b0;
    strt_chk_en  = 1'b0;
    par_chk_en   = 1'b0;
    stp_chk_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Parity mode is frozen for the whole frame at the start edge.
        if (!RX_IN) begin
          state_d    = ST_START;
          par_en_d   = PAR_EN;
          par_flag_d = 1'b0;
        end
      end
      ST_START: begin
        strt_chk_en = chk_pt;
        if (bit_end && (bit_cnt == '0)) begin
          state_d = strt_glitch ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        deser_en = chk_pt;
        if (bit_end && (bit_cnt == DATA_LAST_C)) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        par_chk_en = chk_pt;
        if (bit_end) begin
          state_d    = ST_STOP;
          par_flag_d = par_flag_q | par_err;
        end
      end
      ST_STOP: begin
        stp_chk_en = chk_pt;
        if (bit_end) begin
          state_d = ST_IDLE;
          if (par_flag_q || stp_err) begin
            frame_err_d = 1'b1;
          end else begin
            data_valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
